// File: rtl/uart_mult_byte_tx_if.sv
// Packet-transmit handshake between a packet source (master) and the
// UART packet transmitter (slave).
interface uart_mult_byte_tx_if #(
  parameter int MAX_BYTES = 12
);
  logic                   tx_start;
  logic [7:0]             tx_len;
  logic [MAX_BYTES*8-1:0] tx_data;
  logic                   uart_txd;
  logic                   tx_busy;
  logic                   tx_done;
  logic [7:0]             byte_idx;

  modport master (
    output tx_start, tx_len, tx_data,
    input  uart_txd, tx_busy, tx_done, byte_idx
  );

  modport slave (
    input  tx_start, tx_len, tx_data,
    output uart_txd, tx_busy, tx_done, byte_idx
  );
endinterface

// File: rtl/uart_mult_byte_tx.sv
// Framed UART packet transmitter: HEAD, LEN, payload bytes, CRC8 (poly 0x07)
// over the payload, 8N1 with no gap between bytes.
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// HEAD  | sending the header byte
// LEN   | sending the clamped payload length
// DATA  | sending payload bytes from the shadow register
// CRC   | sending the accumulated CRC8
// FIN   | one-cycle completion pulse, tx_start ignored
module uart_mult_byte_tx #(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         UART_BPS  = 115200,
  parameter int         MAX_BYTES = 12,
  parameter logic [7:0] HEAD_BYTE = 8'h5A
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  uart_mult_byte_tx_if.slave bus
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  typedef enum logic [2:0] {IDLE, HEAD, LEN, DATA, CRC, FIN} state_t;

  state_t                 state_q, state_n;
  logic [BAUD_W-1:0]      baud_q, baud_n;
  logic [3:0]             bit_q, bit_n;
  logic [7:0]             shift_q, shift_n;
  logic [MAX_BYTES*8-1:0] shadow_q, shadow_n;
  logic [7:0]             len_q, len_n;
  logic [7:0]             ptr_q, ptr_n;
  logic [7:0]             crc_q, crc_n;
  logic [7:0]             idx_q, idx_n;
  logic                   txd_q, txd_n;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    shift_n  = shift_q;
    shadow_n = shadow_q;
    len_n    = len_q;
    ptr_n    = ptr_q;
    crc_n    = crc_q;
    idx_n    = idx_q;
    txd_n    = txd_q;
    case (state_q)
      IDLE: begin
        txd_n = 1'b1;
        if (bus.tx_start) begin
          state_n  = HEAD;
          shadow_n = bus.tx_data;
          len_n    = (bus.tx_len > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : bus.tx_len;
          crc_n    = 8'h00;
          ptr_n    = 8'd0;
          shift_n  = HEAD_BYTE;
          baud_n   = '0;
          bit_n    = 4'd0;
          idx_n    = 8'd0;
          txd_n    = 1'b0;
        end
      end
      HEAD, LEN, DATA, CRC: begin
        if (baud_q == BAUD_W'(BPS_CNT - 1)) begin
          baud_n = '0;
          if (bit_q == 4'd9) begin
            // Stop bit finished: load the next byte and start it immediately.
            bit_n = 4'd0;
            txd_n = 1'b0;
            idx_n = idx_q + 8'd1;
            case (state_q)
              HEAD: begin
                state_n = LEN;
                shift_n = len_q;
              end
              LEN, DATA: begin
                if (ptr_q == len_q) begin
                  state_n = CRC;
                  shift_n = crc_q;
                end else begin
                  state_n  = DATA;
                  shift_n  = shadow_q[7:0];
                  shadow_n = shadow_q >> 8;
                  crc_n    = crc8_step(crc_q, shadow_q[7:0]);
                  ptr_n    = ptr_q + 8'd1;
                end
              end
              default: begin
                state_n = FIN;
                txd_n   = 1'b1;
                idx_n   = idx_q;
              end
            endcase
          end else begin
            bit_n = bit_q + 4'd1;
            txd_n = (bit_q == 4'd8) ? 1'b1 : shift_q[bit_q[2:0]];
          end
        end else begin
          baud_n = baud_q + 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 8'h00;
      shadow_q <= '0;
      len_q    <= 8'd0;
      ptr_q    <= 8'd0;
      crc_q    <= 8'h00;
      idx_q    <= 8'd0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_n;
      baud_q   <= baud_n;
      bit_q    <= bit_n;
      shift_q  <= shift_n;
      shadow_q <= shadow_n;
      len_q    <= len_n;
      ptr_q    <= ptr_n;
      crc_q    <= crc_n;
      idx_q    <= idx_n;
      txd_q    <= txd_n;
    end
  end

  assign bus.uart_txd = txd_q;
  assign bus.tx_busy  = (state_q == HEAD) || (state_q == LEN) ||
                        (state_q == DATA) || (state_q == CRC);
  assign bus.tx_done  = (state_q == FIN);
  assign bus.byte_idx = idx_q;
endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx at BPS_CNT=10: decodes the line cycle by cycle
// and compares bytes against a scoreboard filled from a reference packet model.
module tb_uart_mult_byte_tx;
  localparam int MAXB = 12;

  logic sys_clk;
  logic sys_rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] sb_q[$];

  uart_mult_byte_tx_if #(.MAX_BYTES(MAXB)) bus ();

  uart_mult_byte_tx #(
    .CLK_FREQ (1000),
    .UART_BPS (100),
    .MAX_BYTES(MAXB),
    .HEAD_BYTE(8'h5A)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Bitwise MSB-first CRC8, poly 0x07, init 0
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic start_packet(input logic [7:0] len, input logic [MAXB*8-1:0] data, input bit push);
    int         l;
    logic [7:0] c;
    logic [7:0] b;
    l = (len > 8'(MAXB)) ? MAXB : int'(len);
    if (push) begin
      sb_q.push_back(8'h5A);
      sb_q.push_back(8'(l));
      c = 8'h00;
      for (int i = 0; i < l; i++) begin
        b = data[8*i +: 8];
        sb_q.push_back(b);
        c = crc_ref(c, b);
      end
      sb_q.push_back(c);
    end
    bus.tx_len   = len;
    bus.tx_data  = data;
    bus.tx_start = 1'b1;
    tick;
    bus.tx_start = 1'b0;
    bus.tx_data  = {$urandom(), $urandom(), $urandom()};
    bus.tx_len   = 8'd7;
  endtask

  // Entered on the first start-bit cycle; each bit must hold for exactly 10 cycles.
  task automatic rx_packet(input int nbytes, input int mid_pulse, input bit fin_pulse);
    int         cyc;
    logic [9:0] bits;
    bit         unstable;
    bit         busy_bad;
    logic [7:0] exp_b;
    cyc = 0;
    for (int k = 0; k < nbytes; k++) begin
      unstable = 1'b0;
      busy_bad = 1'b0;
      n_checks++;
      if (bus.byte_idx !== 8'(k)) begin
        n_fail++;
        $display("FAIL byte_idx byte %0d: got %0d want %0d", k, bus.byte_idx, k);
      end
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < 10; c++) begin
          if (c == 0) bits[j] = bus.uart_txd;
          else if (bus.uart_txd !== bits[j]) unstable = 1'b1;
          if (bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) busy_bad = 1'b1;
          bus.tx_start = (cyc == mid_pulse);
          tick;
          cyc++;
        end
      end
      bus.tx_start = 1'b0;
      n_checks++;
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || unstable) begin
        n_fail++;
        $display("FAIL frame byte %0d: start=%b stop=%b unstable=%0d want start=0 stop=1 unstable=0",
                 k, bits[0], bits[9], unstable);
      end
      n_checks++;
      if (busy_bad) begin
        n_fail++;
        $display("FAIL busy byte %0d: busy/done wrong during byte, want busy=1 done=0", k);
      end
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL data byte %0d: got %02h want nothing (scoreboard empty)", k, bits[8:1]);
      end else begin
        exp_b = sb_q.pop_front();
        if (bits[8:1] !== exp_b) begin
          n_fail++;
          $display("FAIL data byte %0d: got %02h want %02h", k, bits[8:1], exp_b);
        end
      end
    end
    n_checks++;
    if (bus.tx_done !== 1'b1 || bus.tx_busy !== 1'b0 || bus.uart_txd !== 1'b1) begin
      n_fail++;
      $display("FAIL fin cycle %0d: done=%b busy=%b txd=%b want done=1 busy=0 txd=1",
               cyc, bus.tx_done, bus.tx_busy, bus.uart_txd);
    end
    bus.tx_start = fin_pulse;
    tick;
    bus.tx_start = 1'b0;
    n_checks++;
    if (bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0 || bus.uart_txd !== 1'b1) begin
      n_fail++;
      $display("FAIL post-fin idle: done=%b busy=%b txd=%b want done=0 busy=0 txd=1",
               bus.tx_done, bus.tx_busy, bus.uart_txd);
    end
  endtask

  task automatic test_reset;
    sys_rst_n    = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_len   = 8'd0;
    bus.tx_data  = '0;
    repeat (3) tick;
    n_checks++;
    if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0 || bus.byte_idx !== 8'd0) begin
      n_fail++;
      $display("FAIL reset state: txd=%b busy=%b done=%b idx=%0d want 1 0 0 0",
               bus.uart_txd, bus.tx_busy, bus.tx_done, bus.byte_idx);
    end
    sys_rst_n = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_empty;
    start_packet(8'd0, {$urandom(), $urandom(), $urandom()}, 1'b1);
    rx_packet(3, -1, 1'b0);
  endtask

  task automatic test_ascii;
    logic [MAXB*8-1:0] d;
    d = '0;
    for (int i = 0; i < 9; i++) d[8*i +: 8] = 8'h31 + 8'(i);
    start_packet(8'd9, d, 1'b1);
    rx_packet(12, -1, 1'b0);
  endtask

  task automatic test_clamp;
    start_packet(8'd20, {$urandom(), $urandom(), $urandom()}, 1'b1);
    rx_packet(15, -1, 1'b0);
  endtask

  task automatic test_ignored_starts;
    logic [MAXB*8-1:0] d;
    d = '0;
    d[7:0] = 8'h01;
    start_packet(8'd1, d, 1'b1);
    rx_packet(4, 150, 1'b1);
    start_packet(8'd2, {$urandom(), $urandom(), $urandom()}, 1'b1);
    rx_packet(5, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    start_packet(8'd3, {$urandom(), $urandom(), $urandom()}, 1'b1);
    rx_packet(6, -1, 1'b0);
  endtask

  task automatic test_reset_mid_packet;
    bit bad;
    start_packet(8'd4, {$urandom(), $urandom(), $urandom()}, 1'b0);
    repeat (250) tick;
    sys_rst_n = 1'b0;
    tick;
    sys_rst_n = 1'b1;
    n_checks++;
    if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.byte_idx !== 8'd0 || bus.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset: txd=%b busy=%b idx=%0d done=%b want 1 0 0 0",
               bus.uart_txd, bus.tx_busy, bus.byte_idx, bus.tx_done);
    end
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.tx_done !== 1'b0 || bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0) bad = 1'b1;
      tick;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL after reset: activity seen (done/txd/busy), want silent idle line");
    end
    start_packet(8'd4, {$urandom(), $urandom(), $urandom()}, 1'b1);
    rx_packet(7, -1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_empty;
    test_ascii;
    test_clamp;
    test_ignored_starts;
    test_back_to_back;
    test_reset_mid_packet;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d leftover bytes want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_mult_byte_tx.md
Name: uart_mult_byte_tx

Overview:
Packetised UART transmitter, the outbound counterpart of the multi-byte UART packet receiver. It latches a payload of up to MAX_BYTES bytes on a start pulse and serialises a framed packet on uart_txd: HEAD byte, LEN byte, payload bytes, CRC8 byte. It runs in the 50 MHz system domain and is used to return register read-back and status packets to the host.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer division), 434 at defaults
MAX_BYTES, 12, maximum payload bytes per packet
HEAD_BYTE, 8'h5A, packet header byte

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  reset, synchronous, active-low
tx_start  in  1  single-cycle request to send a packet; accepted only while tx_busy=0
tx_len  in  8  payload byte count; values above MAX_BYTES are clamped to MAX_BYTES
tx_data  in  MAX_BYTES*8  payload; byte k occupies [8k+7:8k]; sampled only in the accept cycle
uart_txd  out  1  serial line, idles high
tx_busy  out  1  high from the cycle after accept until the last stop bit completes
tx_done  out  1  one-cycle pulse at packet completion
byte_idx  out  8  index of the byte currently on the line (0 = HEAD); debug

Behaviour:
- Reset, synchronous, sampled on sys_clk when sys_rst_n=0: uart_txd=1, tx_busy=0, tx_done=0, byte_idx=0. The FSM goes to IDLE and the bit and baud counters clear. Reset mid-packet aborts the packet. The line returns high on the next edge. No tx_done is issued.
- FSM states: IDLE, HEAD, LEN, DATA, CRC, FIN.
- IDLE:
  - When tx_start=1, latch tx_data and the clamped length L into shadow registers and clear crc to 8'h00.
  - Next state is HEAD. The start bit of HEAD drives uart_txd=0 in the cycle after accept.
- Byte serialisation, identical for every byte:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly BPS_CNT cycles, so each byte takes 10*BPS_CNT cycles.
  - There is no inter-byte gap: the next start bit follows the stop bit immediately.
- Byte sequence:
  - HEAD sends HEAD_BYTE, then goes to LEN.
  - LEN sends L. If L=0 it goes to CRC, otherwise to DATA.
  - DATA sends shadow bytes 0..L-1 in order, then goes to CRC.
  - CRC sends the crc register, then goes to FIN.
- byte_idx: 0 for HEAD, 1 for LEN, 2..L+1 for payload, L+2 for CRC. It updates on the first cycle of each start bit.
- CRC8:
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed over payload bytes only (not HEAD, not LEN).
  - Each payload byte is folded in when it is loaded into the shift register, so crc is final before the CRC byte is loaded.
- FIN: lasts one cycle. tx_done=1, tx_busy=0, uart_txd=1, then return to IDLE.
  - A tx_start in the FIN cycle is ignored.
  - A tx_start in the following IDLE cycle is accepted.
- tx_start while tx_busy=1 is ignored, with no queuing. Changes on tx_data/tx_len after accept have no effect on the packet in flight.
- Timing: packet duration from the first start-bit cycle to the end of the last stop bit is exactly (L+3)*10*BPS_CNT cycles. tx_done is asserted in the next cycle.
- Counters:
  - The baud counter counts 0..BPS_CNT-1 and wraps.
  - The bit counter counts 0..9.
  - The payload pointer wraps nowhere; it is bounded by L.

Test Plan:
1. Bench params CLK_FREQ=1000, UART_BPS=100 (BPS_CNT=10); tx_len=0 -> line carries 5A, 00, 00 (CRC).
   - tx_done exactly 300 cycles after the first start-bit cycle.
   - tx_busy high throughout; uart_txd idle high afterwards.
2. tx_len=9, payload ASCII "123456789" (byte0=0x31) -> decoded bytes 5A 09 31 32 33 34 35 36 37 38 39 F4.
   - tx_done 1200 cycles after the start bit.
   - byte_idx steps 0..11.
3. tx_len=20 with MAX_BYTES=12 -> LEN byte 0x0C; exactly 12 payload bytes sent; CRC over those 12 bytes matches the reference model.
4. tx_len=1, data 0x01; tx_start pulsed again mid-packet and in the FIN cycle -> single packet 5A 01 01 07; the extra starts are ignored.
   - A tx_start one cycle after FIN starts a second packet whose start bit appears on the next cycle.
5. Back-to-back bytes -> no idle bit between stop and next start.
   - Each bit width is measured at exactly 10 cycles on every transition.
6. sys_rst_n low for 1 cycle during the DATA state of a tx_len=4 packet -> uart_txd=1, tx_busy=0, byte_idx=0 at the next edge; no tx_done.
   - A subsequent tx_start sends a complete, correct packet.
